ssd_display_arbiter: RTL and testbench
======================================

// Module: ssd_display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between two requesters, e.g. the letter-select
//  path (port 0) and the Morse decode/GCD result path (port 1). Grants ownership round-robin
//  with a minimum hold time, latches the owner's 16-bit hex value, and scans it out.
//  Drives An3..An0 and {Ca..Cg,Dp} of the top level directly; all outputs are registered.
// PARAMETERS
//  SCAN_DIV_BITS  18           digit advances every 2^SCAN_DIV_BITS clocks (~381 Hz @100 MHz)
//  HOLD_CYCLES    100_000_000  minimum ownership time in clocks after a grant (1 s @100 MHz)
//  HOLD_W         27           hold counter width; must satisfy 2^HOLD_W > HOLD_CYCLES
// PORTS
//  Clk     in   1   system clock (board clock, 100 MHz)
//  Reset   in   1   synchronous, active-high reset
//  Req0    in   1   port 0 display request, level; held high while display is wanted
//  Data0   in   16  port 0 value, 4 hex nibbles, [15:12] = leftmost digit
//  Req1    in   1   port 1 display request, level
//  Data1   in   16  port 1 value
//  Gnt0    out  1   port 0 owns the display
//  Gnt1    out  1   port 1 owns the display
//  Owner   out  2   2'b00 none, 2'b01 port 0, 2'b10 port 1 (== {Gnt1,Gnt0})
//  An      out  4   anodes, active-low, An[3] = leftmost digit
//  Cath    out  8   {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high (Clk, Reset).
//  Reset: Gnt0=Gnt1=0, Owner=00, An=4'b1111, Cath=8'hFF, scan cnt=0, hold cnt=0,
//   disp_reg=16'h0000, last_owner=1 (so port 0 wins the first tie).
//  FSM states IDLE, OWN0, OWN1; Gnt*/Owner are the registered state decode.
//  IDLE: Req0&Req1 -> grant port != last_owner; single Req -> grant that port; none -> stay.
//   Gnt rises the cycle after Req is sampled high (1-cycle grant latency).
//  On every grant: hold cnt <= 0, last_owner <= granted port.
//  OWNx: hold cnt increments, saturates at HOLD_CYCLES; held = (hold cnt == HOLD_CYCLES).
//   !held: stay in OWNx regardless of either Req.
//   held & other Req high: switch directly OWNx -> OWNy (no IDLE cycle), hold cnt <= 0.
//   held & other Req low & own Req low: -> IDLE.  held & own Req high: stay.
//  Data: disp_reg <= owner's Data each cycle that owner's Req is high; frozen when it is low
//   (value stays shown until hold expires). On a grant, disp_reg loads the new owner's Data
//   in the same cycle Gnt rises.
//  Scan: free-running (SCAN_DIV_BITS+2)-bit counter, wraps; idx = top 2 bits.
//   idx 0..3 -> An[3]..An[0] low, nibble disp_reg[15:12]..[3:0]. An/Cath registered:
//   1-cycle latency from idx change. Exactly one anode low while OWN0/OWN1.
//  IDLE: An=4'b1111, Cath=8'hFF (display blank); scan counter keeps running.
//  Hex map abcdefg: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//   E=0110000 F=0111000; Dp=1 unless the optional feature drives it.
//  Reset mid-operation: all state returns to reset values next edge; ownership lost.
// CONFIGURATION
//  SSD_ARB_OWNER_DP_EN defined: Dp=0 on the digit An[0] while Owner==10, and on An[3]
//   while Owner==01 (identifies the owning port). Undefined: Dp=1 always.
// TESTING (SCAN_DIV_BITS=2, HOLD_CYCLES=8, HOLD_W=4)
//  Reset, no Req -> An=1111, Cath=FF, Owner=00 for 64 cycles; scan counter still wraps.
//  Req0=1, Data0=16'h12AF -> Gnt0 next cycle; An cycles 0111,1011,1101,1110 every 4 clk;
//   Cath = 1001111_1, 0010010_1, 0001000_1, 0111000_1.
//  Req0&Req1 rise together from reset -> Gnt0 first; hold Req1; Gnt0 persists exactly
//   8 cycles then Gnt1 next with no IDLE cycle; release both -> next tie grants port 0.
//  Req1 pulse 1 cycle with Data1=16'h0042 -> Gnt1 held 8 cycles, display frozen at 0042,
//   then IDLE/blank; Req0 arriving mid-hold waits until hold expires.
//  Reset asserted while OWN1 -> next edge Owner=00, An=1111, Cath=FF.
//  With SSD_ARB_OWNER_DP_EN: OWN1 -> Cath[0]=0 only while An=1110; OWN0 -> only at An=0111.

Source files
------------

// File: rtl/ssd_display_arbiter_if.sv
// Request/data/grant/display bundle for ssd_display_arbiter.
// The master side is the pair of requesters; the slave side is the arbiter.
interface ssd_display_arbiter_if;
   logic        req0;
   logic [15:0] data0;
   logic        req1;
   logic [15:0] data1;
   logic        gnt0;
   logic        gnt1;
   logic [1:0]  owner;
   logic [3:0]  an;
   logic [7:0]  cath;

   modport master (
      output req0, data0, req1, data1,
      input  gnt0, gnt1, owner, an, cath
   );

   modport slave (
      input  req0, data0, req1, data1,
      output gnt0, gnt1, owner, an, cath
   );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Round-robin, minimum-hold arbiter sharing a 4-digit seven-segment display between two ports.
// Optional macro SSD_ARB_OWNER_DP_EN marks the owning port with a decimal point.
module ssd_display_arbiter #(
   parameter int unsigned SCAN_DIV_BITS = 18,
   parameter int unsigned HOLD_CYCLES   = 100_000_000,
   parameter int unsigned HOLD_W        = 27
) (
   input logic                  Clk,
   input logic                  Reset,
   ssd_display_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

   localparam logic [HOLD_W-1:0]        HOLD_MAX = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]        HOLD_ONE = HOLD_W'(1);
   localparam logic [SCAN_DIV_BITS+1:0] SCAN_ONE = (SCAN_DIV_BITS + 2)'(1);

   state_t                 state;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [HOLD_W-1:0]      hold_next;
   logic                   held;
   logic                   last_owner;
   logic [15:0]            disp_reg;
   logic [SCAN_DIV_BITS+1:0] scan_cnt;
   logic [1:0]             idx;
   logic [3:0]             nibble;
   logic [6:0]             seg;
   logic                   dp;
   logic [3:0]             an_q;
   logic [7:0]             cath_q;

   // held is judged on the post-increment count so ownership lasts exactly HOLD_CYCLES clocks
   assign hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_ONE;
   assign held      = (hold_next == HOLD_MAX);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         last_owner <= 1'b1;
         disp_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 && (!bus.req1 || last_owner)) begin
                  state      <= OWN0;
                  hold_cnt   <= '0;
                  last_owner <= 1'b0;
                  disp_reg   <= bus.data0;
               end else if (bus.req1) begin
                  state      <= OWN1;
                  hold_cnt   <= '0;
                  last_owner <= 1'b1;
                  disp_reg   <= bus.data1;
               end
            end
            OWN0: begin
               hold_cnt <= hold_next;
               if (bus.req0) disp_reg <= bus.data0;
               if (held && bus.req1) begin
                  state      <= OWN1;
                  hold_cnt   <= '0;
                  last_owner <= 1'b1;
                  disp_reg   <= bus.data1;
               end else if (held && !bus.req0) begin
                  state <= IDLE;
               end
            end
            OWN1: begin
               hold_cnt <= hold_next;
               if (bus.req1) disp_reg <= bus.data1;
               if (held && bus.req0) begin
                  state      <= OWN0;
                  hold_cnt   <= '0;
                  last_owner <= 1'b0;
                  disp_reg   <= bus.data0;
               end else if (held && !bus.req1) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt0  = (state == OWN0);
   assign bus.gnt1  = (state == OWN1);
   assign bus.owner = {bus.gnt1, bus.gnt0};

   assign idx = scan_cnt[SCAN_DIV_BITS +: 2];

   always_comb begin
      nibble = '0;
      case (idx)
         2'd0:    nibble = disp_reg[15:12];
         2'd1:    nibble = disp_reg[11:8];
         2'd2:    nibble = disp_reg[7:4];
         default: nibble = disp_reg[3:0];
      endcase
   end

   always_comb begin
      seg = '1;
      case (nibble)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
   end

`ifdef SSD_ARB_OWNER_DP_EN
   // port 1 lights the rightmost point, port 0 the leftmost
   assign dp = !((state == OWN1 && idx == 2'd3) || (state == OWN0 && idx == 2'd0));
`else
   assign dp = 1'b1;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         scan_cnt <= '0;
         an_q     <= 4'hF;
         cath_q   <= 8'hFF;
      end else begin
         scan_cnt <= scan_cnt + SCAN_ONE;
         if (state == IDLE) begin
            an_q   <= 4'hF;
            cath_q <= 8'hFF;
         end else begin
            an_q   <= ~(4'b1000 >> idx);
            cath_q <= {seg, dp};
         end
      end
   end

   assign bus.an   = an_q;
   assign bus.cath = cath_q;
endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter: vector table, directed hold/tie/reset
// sequences, and randomized traffic against a cycle-level reference model.
module tb_ssd_display_arbiter;
   localparam int unsigned SDB  = 2;
   localparam int unsigned HOLD = 8;
   localparam int unsigned HW   = 4;
`ifdef SSD_ARB_OWNER_DP_EN
   localparam bit DP_ON = 1'b1;
`else
   localparam bit DP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   ssd_display_arbiter_if bus();

   ssd_display_arbiter #(
      .SCAN_DIV_BITS(SDB),
      .HOLD_CYCLES  (HOLD),
      .HOLD_W       (HW)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: owner (0 none, 1 port0, 2 port1), cycles owned so far, scan position.
   int          m_owner, m_age, m_last, m_scan;
   logic [15:0] m_disp;
   logic [3:0]  m_an;
   logic [7:0]  m_cath;
   logic [6:0]  seg [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic grant(input int p);
      m_owner = p + 1;
      m_age   = 1;
      m_last  = p;
      m_disp  = (p == 1) ? bus.data1 : bus.data0;
   endtask

   task automatic model_step();
      int idx, nib, q;
      bit dp, own, oth;
      if (rst) begin
         m_owner = 0; m_age = 0; m_last = 1; m_scan = 0;
         m_disp = '0; m_an = 4'hF; m_cath = 8'hFF;
         return;
      end
      if (m_owner == 0) begin
         m_an = 4'hF; m_cath = 8'hFF;
      end else begin
         idx = (m_scan >> SDB) % 4;
         nib = int'((m_disp >> (4 * (3 - idx))) & 16'hF);
         m_an = 4'hF;
         m_an[3 - idx] = 1'b0;
         dp = !(DP_ON && ((m_owner == 2 && idx == 3) || (m_owner == 1 && idx == 0)));
         m_cath = {seg[nib], dp};
      end
      if (m_owner == 0) begin
         if (bus.req0 && bus.req1) grant((m_last == 1) ? 0 : 1);
         else if (bus.req0)        grant(0);
         else if (bus.req1)        grant(1);
      end else begin
         q   = m_owner - 1;
         own = (q == 1) ? bus.req1 : bus.req0;
         oth = (q == 1) ? bus.req0 : bus.req1;
         if (m_age < HOLD) begin
            m_age++;
            if (own) m_disp = (q == 1) ? bus.data1 : bus.data0;
         end else if (oth) begin
            grant(1 - q);
         end else if (own) begin
            m_disp = (q == 1) ? bus.data1 : bus.data0;
         end else begin
            m_owner = 0;
         end
      end
      m_scan = (m_scan + 1) % (4 << SDB);
   endtask

   task automatic tick();
      logic [1:0] mo;
      @(posedge clk);
      model_step();
      #1;
      mo = m_owner[1:0];
      check("model", {bus.gnt1, bus.gnt0, bus.owner, bus.an, bus.cath},
            {mo[1], mo[0], mo, m_an, m_cath});
   endtask

   task automatic do_reset();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_state", {bus.owner, bus.an, bus.cath}, {2'b00, 4'hF, 8'hFF});
   endtask

   typedef struct {
      logic        r0, r1;
      logic [15:0] d0, d1;
      logic [1:0]  owner;
      logic [3:0]  an;
      logic [7:0]  cath;
   } vec_t;

   vec_t       vec [16];
   logic [3:0] an_exp   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   logic [7:0] cath_exp [4] = '{8'h9F, 8'h25, 8'h11, 8'h71};
   int         cnt;

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
      rst = 1'b1;
      if (DP_ON) cath_exp[0] = 8'h9E;

      // Steady display of 12AF on port 0; row k is the k-th clock after the request.
      vec[0] = '{1'b1, 1'b0, 16'h12AF, 16'h0000, 2'b01, 4'hF, 8'hFF};
      for (int k = 1; k < 16; k++)
         vec[k] = '{1'b1, 1'b0, 16'h12AF, 16'h0000, 2'b01, an_exp[k >> 2], cath_exp[k >> 2]};

      // Idle after reset: blank for 64 cycles, scan keeps counting.
      do_reset();
      for (int i = 0; i < 64; i++) begin
         tick();
         check("idle_blank", {bus.owner, bus.an, bus.cath}, {2'b00, 4'hF, 8'hFF});
      end

      for (int k = 0; k < 16; k++) begin
         bus.req0 = vec[k].r0; bus.req1 = vec[k].r1;
         bus.data0 = vec[k].d0; bus.data1 = vec[k].d1;
         tick();
         check("vec_owner", bus.owner, vec[k].owner);
         check("vec_an", bus.an, vec[k].an);
         check("vec_cath", bus.cath, vec[k].cath);
      end

      // Simultaneous requests: port 0 first, 8-cycle hold, direct switch, round-robin resumes.
      do_reset();
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 16'h1111; bus.data1 = 16'h2222;
      tick();
      check("tie_first", bus.owner, 2'b01);
      cnt = 1;
      while (bus.owner == 2'b01 && cnt < 20) begin
         tick();
         if (bus.owner == 2'b01) cnt++;
      end
      check("tie_hold_len", cnt, 8);
      check("tie_switch", bus.owner, 2'b10);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      cnt = 0;
      while (bus.owner != 2'b00 && cnt < 20) begin
         tick();
         cnt++;
      end
      check("tie_port1_len", cnt, 8);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      tick();
      check("tie_rr", bus.owner, 2'b01);

      // One-cycle request on port 1: display frozen at 0042 for the hold, then blank.
      do_reset();
      repeat (8) tick();
      bus.req1 = 1'b1; bus.data1 = 16'h0042;
      tick();
      check("pulse_grant", bus.owner, 2'b10);
      bus.req1 = 1'b0; bus.data1 = 16'hFFFF;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("pulse_hold", bus.owner, 2'b10);
         check("pulse_an", bus.an, (i < 3) ? 4'b1101 : 4'b1110);
         check("pulse_cath", bus.cath, (i < 3) ? 8'h99 : (DP_ON ? 8'h24 : 8'h25));
      end
      tick();
      check("pulse_idle", bus.owner, 2'b00);
      tick();
      check("pulse_blank", {bus.an, bus.cath}, {4'hF, 8'hFF});

      // Port 0 arriving mid-hold waits for expiry, then takes over directly.
      bus.req1 = 1'b1; bus.data1 = 16'h0042;
      tick();
      check("mid_grant", bus.owner, 2'b10);
      bus.req1 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin bus.req0 = 1'b1; bus.data0 = 16'hBEEF; end
         tick();
         check("mid_wait", bus.owner, 2'b10);
      end
      tick();
      check("mid_switch", bus.owner, 2'b01);

      // Reset while port 1 owns the display.
      do_reset();
      bus.req1 = 1'b1;
      tick();
      tick();
      tick();
      check("rst_pre", bus.owner, 2'b10);
      rst = 1'b1;
      tick();
      check("rst_mid", {bus.owner, bus.an, bus.cath}, {2'b00, 4'hF, 8'hFF});
      rst = 1'b0; bus.req1 = 1'b0;

      // Randomized traffic against the model, with occasional resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) bus.req0 = ~bus.req0;
         if ($urandom_range(7) == 0) bus.req1 = ~bus.req1;
         bus.data0 = 16'($urandom);
         bus.data1 = 16'($urandom);
         rst = ($urandom_range(499) == 0);
         tick();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
